// File: rtl/decode_stage.sv
// Pipelined instruction decoder: valid/ready input, 2-entry skid-buffered output bundle, illegal-opcode counter.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal words halt the stage (trap) instead of flowing through as NOPs.
module decode_stage #(
    parameter int INS_W     = 13,
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INS_W-1:0]     ins,
    input  logic                 flush,
    input  logic                 trap_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 dm_we,
    output logic                 reg_ce,
    output logic [NUM_REGS-1:0]  reg_addr,
    output logic [DATA_W-1:0]    data,
    output logic [1:0]           sel_src,
    output logic [2:0]           alu_code,
    output logic                 carry_ce,
    output logic                 accu_ce,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt,
    output logic                 trap
);
    localparam int REG_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [NUM_REGS-1:0] ONE_HOT_BASE = NUM_REGS'(1);

    typedef struct packed {
        logic                dm_we;
        logic                reg_ce;
        logic [NUM_REGS-1:0] reg_addr;
        logic [DATA_W-1:0]   data;
        logic [1:0]          sel_src;
        logic [2:0]          alu_code;
        logic                carry_ce;
        logic                accu_ce;
        logic                illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    bundle_t                main_q, main_d;
    bundle_t                skid_q, skid_d;
    logic                   in_ready_q, in_ready_d;
    logic [ILL_CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic                   trap_q, trap_d;

    logic [4:0]             op;
    logic [1:0]             sec;
    logic [2:0]             sub;
    logic [REG_BITS-1:0]    rnum;
    bundle_t                dec;
    logic                   bad;
    logic                   push;
    logic                   pop;
    logic                   enq;

    assign op   = ins[INS_W-1 -: 5];
    assign sec  = op[4:3];
    assign sub  = op[2:0];
    assign rnum = ins[INS_W-6 -: REG_BITS];

    always_comb begin
        dec          = '0;
        bad          = 1'b0;
        dec.data     = ins[DATA_W-1:0];
        dec.reg_addr = ONE_HOT_BASE << rnum;
        if (32'(rnum) >= NUM_REGS) begin
            bad = 1'b1;
        end
        if (sec == 2'd3) begin
            case (sub)
                3'd0, 3'd1, 3'd2: begin
                    dec.sel_src  = sub[1:0];
                    dec.alu_code = 3'd6;
                    dec.accu_ce  = 1'b1;
                end
                3'd3: begin
                    dec.reg_ce   = 1'b1;
                    dec.sel_src  = 2'd0;
                    dec.alu_code = 3'd7;
                end
                3'd4: begin
                    dec.dm_we    = 1'b1;
                    dec.sel_src  = 2'd1;
                    dec.alu_code = 3'd7;
                end
                default: bad = 1'b1;
            endcase
        end else begin
            dec.sel_src = sec;
            if (sub <= 3'd5) begin
                dec.alu_code = sub;
                dec.carry_ce = (sub <= 3'd1);
                dec.accu_ce  = 1'b1;
            end else begin
                bad = 1'b1;
            end
        end
        // An illegal word keeps its decoded operand fields but loses every side effect.
        if (bad) begin
            dec.dm_we    = 1'b0;
            dec.reg_ce   = 1'b0;
            dec.carry_ce = 1'b0;
            dec.accu_ce  = 1'b0;
            dec.alu_code = 3'd7;
        end
        dec.illegal = bad;
    end

    assign push = in_valid && in_ready_q;
    assign pop  = (state_q != EMPTY) && out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign enq = push && !dec.illegal;

    always_comb begin
        trap_d = trap_q;
        if (flush || (trap_q && trap_clr)) begin
            trap_d = 1'b0;
        end else if (push && dec.illegal) begin
            trap_d = 1'b1;
        end
    end
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign enq             = push;
    assign trap_d          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            if (push && dec.illegal && (ill_cnt_q != '1)) begin
                ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
            end
            case (state_q)
                EMPTY: begin
                    if (enq) begin
                        state_d = FULL;
                        main_d  = dec;
                    end
                end
                FULL: begin
                    if (enq && pop) begin
                        main_d = dec;
                    end else if (enq) begin
                        state_d = SKID;
                        skid_d  = dec;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        in_ready_d = (state_d != SKID) && !trap_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            ill_cnt_q  <= '0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            ill_cnt_q  <= ill_cnt_d;
            trap_q     <= trap_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign dm_we     = main_q.dm_we;
    assign reg_ce    = main_q.reg_ce;
    assign reg_addr  = main_q.reg_addr;
    assign data      = main_q.data;
    assign sel_src   = main_q.sel_src;
    assign alu_code  = main_q.alu_code;
    assign carry_ce  = main_q.carry_ce;
    assign accu_ce   = main_q.accu_ce;
    assign illegal   = main_q.illegal;
    assign ill_cnt   = ill_cnt_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode vectors, skid backpressure, flush, illegal counting, async reset.
module tb_decode_stage;
    localparam int INS_W     = 13;
    localparam int DATA_W    = 8;
    localparam int NUM_REGS  = 4;
    localparam int ILL_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [INS_W-1:0]     ins = '0;
    logic                 flush = 1'b0;
    logic                 trap_clr = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 dm_we;
    logic                 reg_ce;
    logic [NUM_REGS-1:0]  reg_addr;
    logic [DATA_W-1:0]    data;
    logic [1:0]           sel_src;
    logic [2:0]           alu_code;
    logic                 carry_ce;
    logic                 accu_ce;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;
    logic                 trap;

    int checkCount = 0;
    int errorCount = 0;

    decode_stage #(
        .INS_W(INS_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ILL_CNT_W(ILL_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ins(ins),
        .flush(flush), .trap_clr(trap_clr), .out_valid(out_valid), .out_ready(out_ready),
        .dm_we(dm_we), .reg_ce(reg_ce), .reg_addr(reg_addr), .data(data),
        .sel_src(sel_src), .alu_code(alu_code), .carry_ce(carry_ce), .accu_ce(accu_ce),
        .illegal(illegal), .ill_cnt(ill_cnt), .trap(trap)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic applyStimulus(input logic v, input logic [INS_W-1:0] w, input logic ordy,
                                 input logic fl, input logic tc);
        in_valid  = v;
        ins       = w;
        out_ready = ordy;
        flush     = fl;
        trap_clr  = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Power-on reset
        #2 rst = 1'b1;
        #10;
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_in_ready",  32'(in_ready), 0);
        checkOutput("rst_data",      32'(data), 0);
        checkOutput("rst_ill_cnt",   32'(ill_cnt), 0);
        checkOutput("rst_trap",      32'(trap), 0);
        #6 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready",  32'(in_ready), 1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 0);

        // ADD R2, 0x80
        applyStimulus(1'b1, 13'h0080, 1'b1, 1'b0, 1'b0);
        checkOutput("add_valid",    32'(out_valid), 1);
        checkOutput("add_reg_addr", 32'(reg_addr), 32'h4);
        checkOutput("add_alu",      32'(alu_code), 0);
        checkOutput("add_carry",    32'(carry_ce), 1);
        checkOutput("add_accu",     32'(accu_ce), 1);
        checkOutput("add_src",      32'(sel_src), 0);
        checkOutput("add_data",     32'(data), 32'h80);
        checkOutput("add_illegal",  32'(illegal), 0);

        // ST_DM 0x3F
        applyStimulus(1'b1, 13'h1C3F, 1'b1, 1'b0, 1'b0);
        checkOutput("stdm_we",    32'(dm_we), 1);
        checkOutput("stdm_alu",   32'(alu_code), 7);
        checkOutput("stdm_src",   32'(sel_src), 1);
        checkOutput("stdm_data",  32'(data), 32'h3F);
        checkOutput("stdm_accu",  32'(accu_ce), 0);
        checkOutput("stdm_carry", 32'(carry_ce), 0);

        // ST_R R1
        applyStimulus(1'b1, 13'h1B40, 1'b1, 1'b0, 1'b0);
        checkOutput("str_reg_ce",   32'(reg_ce), 1);
        checkOutput("str_reg_addr", 32'(reg_addr), 32'h2);
        checkOutput("str_dm_we",    32'(dm_we), 0);
        checkOutput("str_alu",      32'(alu_code), 7);

        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0, 1'b0);
        checkOutput("drain_valid",    32'(out_valid), 0);
        checkOutput("drain_reg_addr", 32'(reg_addr), 0);
        checkOutput("drain_data",     32'(data), 0);

        // Backpressure: SUB 0x40, AND 0x90, OR 0x55 with out_ready low
        applyStimulus(1'b1, 13'h0140, 1'b0, 1'b0, 1'b0);
        checkOutput("bp1_valid",    32'(out_valid), 1);
        checkOutput("bp1_in_ready", 32'(in_ready), 1);
        checkOutput("bp1_alu",      32'(alu_code), 1);
        applyStimulus(1'b1, 13'h0290, 1'b0, 1'b0, 1'b0);
        checkOutput("bp2_in_ready", 32'(in_ready), 0);
        checkOutput("bp2_data",     32'(data), 32'h40);
        applyStimulus(1'b1, 13'h0355, 1'b0, 1'b0, 1'b0);
        checkOutput("bp3_in_ready", 32'(in_ready), 0);
        checkOutput("bp3_data",     32'(data), 32'h40);
        applyStimulus(1'b1, 13'h0355, 1'b1, 1'b0, 1'b0);
        checkOutput("bp4_data",     32'(data), 32'h90);
        checkOutput("bp4_alu",      32'(alu_code), 2);
        checkOutput("bp4_reg_addr", 32'(reg_addr), 32'h4);
        checkOutput("bp4_in_ready", 32'(in_ready), 1);
        applyStimulus(1'b1, 13'h0355, 1'b1, 1'b0, 1'b0);
        checkOutput("bp5_data",     32'(data), 32'h55);
        checkOutput("bp5_alu",      32'(alu_code), 3);
        checkOutput("bp5_reg_addr", 32'(reg_addr), 32'h2);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0, 1'b0);
        checkOutput("bp6_valid",    32'(out_valid), 0);

        // Flush from SKID, then flush with a simultaneous illegal push
        applyStimulus(1'b1, 13'h0080, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 13'h1B40, 1'b0, 1'b0, 1'b0);
        checkOutput("fl_skid_in_ready", 32'(in_ready), 0);
        applyStimulus(1'b1, 13'h1D00, 1'b0, 1'b1, 1'b0);
        checkOutput("fl1_valid",    32'(out_valid), 0);
        checkOutput("fl1_in_ready", 32'(in_ready), 1);
        checkOutput("fl1_data",     32'(data), 0);
        checkOutput("fl1_ill_cnt",  32'(ill_cnt), 0);
        applyStimulus(1'b1, 13'h0080, 1'b0, 1'b0, 1'b0);
        checkOutput("fl2_pre_data", 32'(data), 32'h80);
        applyStimulus(1'b1, 13'h1D00, 1'b0, 1'b1, 1'b0);
        checkOutput("fl2_valid",    32'(out_valid), 0);
        checkOutput("fl2_ill_cnt",  32'(ill_cnt), 0);
        checkOutput("fl2_trap",     32'(trap), 0);

`ifdef DECODE_ILLEGAL_TRAP_EN
        // Illegal word traps the stage
        applyStimulus(1'b1, 13'h1D00, 1'b1, 1'b0, 1'b0);
        checkOutput("trap_set",      32'(trap), 1);
        checkOutput("trap_in_ready", 32'(in_ready), 0);
        checkOutput("trap_valid",    32'(out_valid), 0);
        checkOutput("trap_ill_cnt",  32'(ill_cnt), 1);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0, 1'b1);
        checkOutput("trap_clr_trap",     32'(trap), 0);
        checkOutput("trap_clr_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 13'h0600, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0, 1'b1);
        end
        checkOutput("sat_trap", 32'(trap), 0);
`else
        // Illegal words flow as NOP bundles
        applyStimulus(1'b1, 13'h1D00, 1'b1, 1'b0, 1'b0);
        checkOutput("ill1_valid",    32'(out_valid), 1);
        checkOutput("ill1_illegal",  32'(illegal), 1);
        checkOutput("ill1_alu",      32'(alu_code), 7);
        checkOutput("ill1_dm_we",    32'(dm_we), 0);
        checkOutput("ill1_reg_ce",   32'(reg_ce), 0);
        checkOutput("ill1_reg_addr", 32'(reg_addr), 32'h1);
        checkOutput("ill1_ill_cnt",  32'(ill_cnt), 1);
        checkOutput("ill1_trap",     32'(trap), 0);
        applyStimulus(1'b1, 13'h0600, 1'b1, 1'b0, 1'b0);
        checkOutput("ill2_illegal",  32'(illegal), 1);
        checkOutput("ill2_alu",      32'(alu_code), 7);
        checkOutput("ill2_carry",    32'(carry_ce), 0);
        checkOutput("ill2_accu",     32'(accu_ce), 0);
        checkOutput("ill2_src",      32'(sel_src), 0);
        checkOutput("ill2_ill_cnt",  32'(ill_cnt), 2);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 13'h0600, 1'b1, 1'b0, 1'b0);
        end
`endif
        checkOutput("sat_ill_cnt", 32'(ill_cnt), 32'hFF);
        applyStimulus(1'b0, 13'h0000, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_drain_valid", 32'(out_valid), 0);
        checkOutput("sat_hold_cnt",    32'(ill_cnt), 32'hFF);

        // Asynchronous reset mid-stream with both entries occupied
        applyStimulus(1'b1, 13'h0080, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 13'h1C3F, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_pre_in_ready", 32'(in_ready), 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        #2;
        checkOutput("mid_rst_valid",    32'(out_valid), 0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 0);
        checkOutput("mid_rst_data",     32'(data), 0);
        checkOutput("mid_rst_reg_addr", 32'(reg_addr), 0);
        checkOutput("mid_rst_alu",      32'(alu_code), 0);
        checkOutput("mid_rst_accu",     32'(accu_ce), 0);
        checkOutput("mid_rst_ill_cnt",  32'(ill_cnt), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_post_in_ready", 32'(in_ready), 1);
        checkOutput("mid_post_valid",    32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
